// File: rtl/besthop_select.sv
// besthop_select
//   Upstream stage of the reward block. On start it walks the neighbour
//   Q-value table in node memory, picks the neighbour with the highest
//   (unsigned) Q-value and then fetches that neighbour's node ID. Ties keep
//   the lowest index. Memory reads are combinational: data_in reflects the
//   word at the registered address in the same cycle.
//
// Ports
//   clock        in   1   rising-edge clock
//   nrst         in   1   asynchronous active-low reset
//   en           in   1   arms the block while idle
//   start        in   1   begins a scan while armed
//   data_in      in   16  memory read data for the current address
//   address      out  16  registered memory word address
//   besthop      out  16  index of selected neighbour (16'hFFFF when none)
//   best_node_id out  16  node ID of selected neighbour
//   best_q       out  16  Q-value of selected neighbour
//   found        out  1   at least one neighbour scanned, results valid
//   done         out  1   scan complete; held until the next en is accepted

module besthop_select #(
    parameter logic [15:0] COUNT_ADDR = 16'h0006,
    parameter logic [15:0] NEIGH_BASE = 16'h0008,
    parameter logic [15:0] QVAL_BASE  = 16'h00C8,
    parameter int unsigned MAX_NEIGH  = 32
) (
    input  logic        clock,
    input  logic        nrst,
    input  logic        en,
    input  logic        start,
    input  logic [15:0] data_in,
    output logic [15:0] address,
    output logic [15:0] besthop,
    output logic [15:0] best_node_id,
    output logic [15:0] best_q,
    output logic        found,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        RD_CNT,
        RD_Q,
        RD_ID,
        DONE
    } state_t;

    localparam logic [15:0] MAX_CNT = 16'(MAX_NEIGH);

    state_t      state, state_d;
    logic [15:0] address_d, besthop_d, best_node_id_d, best_q_d;
    logic        found_d, done_d;
    logic [15:0] cnt, cnt_d;
    logic [15:0] idx, idx_d;

    logic [15:0] cnt_clamped;
    logic        take_q;
    logic [15:0] hop_upd;
    logic [15:0] idx_next;

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first so
        // that no path leaves it unassigned and infers a latch.
        state_d        = state;
        address_d      = address;
        besthop_d      = besthop;
        best_node_id_d = best_node_id;
        best_q_d       = best_q;
        found_d        = found;
        done_d         = done;
        cnt_d          = cnt;
        idx_d          = idx;

        cnt_clamped = (data_in > MAX_CNT) ? MAX_CNT : data_in;
        // Index 0 always seeds the running best; later entries must be
        // strictly greater so the lowest index wins a tie.
        take_q      = (idx == 16'd0) || (data_in > best_q);
        hop_upd     = take_q ? idx : besthop;
        idx_next    = idx + 16'd1;

        unique case (state)
            IDLE: begin
                if (en) begin
                    state_d = ARMED;
                    done_d  = 1'b0;
                end
            end
            ARMED: begin
                if (start) begin
                    state_d   = RD_CNT;
                    address_d = COUNT_ADDR;
                end
            end
            RD_CNT: begin
                cnt_d = cnt_clamped;
                idx_d = 16'd0;
                if (cnt_clamped == 16'd0) begin
                    found_d   = 1'b0;
                    besthop_d = 16'hFFFF;
                    state_d   = DONE;
                end else begin
                    address_d = QVAL_BASE;
                    state_d   = RD_Q;
                end
            end
            RD_Q: begin
                if (take_q) begin
                    best_q_d  = data_in;
                    besthop_d = idx;
                end
                if (idx == cnt - 16'd1) begin
                    // Fetch the ID of the winner including this cycle's update.
                    address_d = NEIGH_BASE + (hop_upd << 1);
                    state_d   = RD_ID;
                end else begin
                    idx_d     = idx_next;
                    address_d = QVAL_BASE + (idx_next << 1);
                end
            end
            RD_ID: begin
                best_node_id_d = data_in;
                found_d        = 1'b1;
                state_d        = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            address      <= 16'h0000;
            besthop      <= 16'h0000;
            best_node_id <= 16'h0000;
            best_q       <= 16'h0000;
            found        <= 1'b0;
            done         <= 1'b0;
            cnt          <= 16'h0000;
            idx          <= 16'h0000;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the pre-edge values, independent of statement order.
            state        <= state_d;
            address      <= address_d;
            besthop      <= besthop_d;
            best_node_id <= best_node_id_d;
            best_q       <= best_q_d;
            found        <= found_d;
            done         <= done_d;
            cnt          <= cnt_d;
            idx          <= idx_d;
        end
    end

endmodule

// File: tb/tb_besthop_select.sv
// Directed testbench for besthop_select: a small word memory model feeds
// data_in combinationally from address; each scenario task computes its own
// expected results by hand.

module tb_besthop_select;

    logic        clock;
    logic        nrst;
    logic        en;
    logic        start;
    logic [15:0] data_in;
    logic [15:0] address;
    logic [15:0] besthop;
    logic [15:0] best_node_id;
    logic [15:0] best_q;
    logic        found;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:511];
    logic        track;
    logic [15:0] max_addr;
    logic [15:0] last_q_addr;
    int          got_off;

    besthop_select dut (
        .clock        (clock),
        .nrst         (nrst),
        .en           (en),
        .start        (start),
        .data_in      (data_in),
        .address      (address),
        .besthop      (besthop),
        .best_node_id (best_node_id),
        .best_q       (best_q),
        .found        (found),
        .done         (done)
    );

    always #5 clock = ~clock;

    assign data_in = (address[15:10] == 6'd0) ? mem[address[9:1]] : 16'h0000;

    // Records addresses presented to memory while a scan is being tracked.
    always @(posedge clock) begin
        if (track) begin
            if (address > max_addr) max_addr = address;
            if (address >= 16'h00C8) last_q_addr = address;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    endtask

    task automatic set_cnt(input int n);
        mem[16'h0006 >> 1] = 16'(n);
    endtask

    task automatic set_q(input int i, input logic [15:0] v);
        mem[(16'h00C8 + 2 * i) >> 1] = v;
    endtask

    task automatic set_id(input int i, input logic [15:0] v);
        mem[(16'h0008 + 2 * i) >> 1] = v;
    endtask

    task automatic arm();
        @(negedge clock);
        en = 1'b1;
        @(posedge clock);
        #1 en = 1'b0;
    endtask

    // Start is sampled at edge k; tracking begins just after that edge.
    task automatic fire();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        max_addr    = 16'h0000;
        last_q_addr = 16'h0000;
        track       = 1'b1;
    endtask

    // got_off = j such that done is first seen high just before edge k+j.
    // Optionally pulses start and en mid-scan, which must be ignored.
    task automatic wait_done(input bit pulse_mid);
        got_off = -1;
        for (int j = 1; j <= 200; j++) begin
            @(negedge clock);
            if (pulse_mid && j == 2) begin
                start = 1'b1;
                en    = 1'b1;
            end
            if (pulse_mid && j == 3) begin
                start = 1'b0;
                en    = 1'b0;
            end
            if (done === 1'b1) begin
                got_off = j;
                break;
            end
        end
        start = 1'b0;
        en    = 1'b0;
        track = 1'b0;
    endtask

    task automatic check_result(input string name, input int exp_off,
                                input logic [15:0] exp_hop, input logic [15:0] exp_q,
                                input logic [15:0] exp_id, input logic exp_found);
        n_checks++;
        if (got_off != exp_off) begin
            n_fail++;
            $display("FAIL %s_latency: done at edge k+%0d, expected k+%0d", name, got_off, exp_off);
        end
        n_checks++;
        if (besthop !== exp_hop) begin
            n_fail++;
            $display("FAIL %s_besthop: got %h expected %h", name, besthop, exp_hop);
        end
        n_checks++;
        if (best_q !== exp_q) begin
            n_fail++;
            $display("FAIL %s_best_q: got %h expected %h", name, best_q, exp_q);
        end
        n_checks++;
        if (best_node_id !== exp_id) begin
            n_fail++;
            $display("FAIL %s_best_node_id: got %h expected %h", name, best_node_id, exp_id);
        end
        n_checks++;
        if (found !== exp_found) begin
            n_fail++;
            $display("FAIL %s_found: got %b expected %b", name, found, exp_found);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({address, besthop, best_node_id, best_q, found, done} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%h hop=%h id=%h q=%h found=%b done=%b expected all zero",
                     address, besthop, best_node_id, best_q, found, done);
        end
        @(negedge clock);
        nrst = 1'b1;
    endtask

    task automatic load_basic();
        clear_mem();
        set_cnt(3);
        set_q(0, 16'h0010); set_q(1, 16'h0050); set_q(2, 16'h0020);
        set_id(0, 16'h000A); set_id(1, 16'h000B); set_id(2, 16'h000C);
    endtask

    task automatic test_basic();
        load_basic();
        arm();
        fire();
        wait_done(1'b0);
        check_result("basic", 7, 16'h0001, 16'h0050, 16'h000B, 1'b1);
    endtask

    task automatic test_reset_mid_scan();
        clear_mem();
        set_cnt(10);
        for (int i = 0; i < 10; i++) begin
            set_q(i, 16'h0100 + 16'(i));
            set_id(i, 16'h0200 + 16'(i));
        end
        arm();
        fire();
        repeat (3) @(posedge clock);
        #2 nrst = 1'b0;
        #1;
        track = 1'b0;
        n_checks++;
        if ({address, besthop, best_node_id, best_q, found, done} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_mid_scan: got addr=%h hop=%h id=%h q=%h found=%b done=%b expected all zero",
                     address, besthop, best_node_id, best_q, found, done);
        end
        @(negedge clock);
        nrst = 1'b1;
        // Back in IDLE: start without en must not launch a scan.
        start = 1'b1;
        repeat (3) @(negedge clock);
        start = 1'b0;
        n_checks++;
        if (address !== 16'h0000 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got addr=%h done=%b expected addr=0000 done=0", address, done);
        end
    endtask

    task automatic test_tie();
        clear_mem();
        set_cnt(4);
        set_q(0, 16'd5); set_q(1, 16'd9); set_q(2, 16'd9); set_q(3, 16'd2);
        set_id(0, 16'h0021); set_id(1, 16'h0022); set_id(2, 16'h0023); set_id(3, 16'h0024);
        arm();
        fire();
        wait_done(1'b0);
        check_result("tie", 8, 16'h0001, 16'h0009, 16'h0022, 1'b1);
    endtask

    task automatic test_empty();
        clear_mem();
        set_cnt(0);
        set_q(0, 16'h1234);
        set_id(0, 16'h4321);
        arm();
        fire();
        wait_done(1'b0);
        // best_q and best_node_id keep the previous scan's values.
        check_result("empty", 3, 16'hFFFF, 16'h0009, 16'h0022, 1'b0);
        n_checks++;
        if (max_addr !== 16'h0006) begin
            n_fail++;
            $display("FAIL empty_max_addr: got %h expected %h", max_addr, 16'h0006);
        end
    endtask

    task automatic test_clamp();
        clear_mem();
        set_cnt(100);
        for (int i = 0; i < 100; i++) begin
            set_q(i, 16'(i + 1));
            set_id(i, 16'h0100 + 16'(i));
        end
        set_q(31, 16'h7FFF);
        set_q(40, 16'hFFFF);
        arm();
        fire();
        wait_done(1'b0);
        check_result("clamp", 36, 16'd31, 16'h7FFF, 16'h011F, 1'b1);
        n_checks++;
        if (last_q_addr !== 16'h0106) begin
            n_fail++;
            $display("FAIL clamp_last_q_addr: got %h expected %h", last_q_addr, 16'h0106);
        end
    endtask

    task automatic test_back_to_back();
        // Scan A with start/en pulsed mid-scan.
        clear_mem();
        set_cnt(3);
        set_q(0, 16'h0030); set_q(1, 16'h0010); set_q(2, 16'h0040);
        set_id(0, 16'h0051); set_id(1, 16'h0052); set_id(2, 16'h0053);
        arm();
        fire();
        wait_done(1'b1);
        check_result("hs_a", 7, 16'h0002, 16'h0040, 16'h0053, 1'b1);

        // done and results hold while en stays low.
        repeat (5) @(negedge clock);
        n_checks++;
        if (done !== 1'b1 || besthop !== 16'h0002) begin
            n_fail++;
            $display("FAIL hs_hold: got done=%b hop=%h expected done=1 hop=0002", done, besthop);
        end

        // done clears on the edge where en is accepted.
        en = 1'b1;
        #1;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL hs_done_before_en_edge: got %b expected 1", done);
        end
        @(posedge clock);
        #1 en = 1'b0;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_done_clear: got %b expected 0", done);
        end

        // Scan B, already armed.
        load_basic();
        fire();
        wait_done(1'b0);
        check_result("hs_b", 7, 16'h0001, 16'h0050, 16'h000B, 1'b1);

        // en and start together only arm the block.
        @(negedge clock);
        en    = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1;
        en    = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (address !== 16'h000A || done !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_en_start_together: got addr=%h done=%b expected addr=000a done=0", address, done);
        end

        // Scan C from ARMED with a fresh table.
        clear_mem();
        set_cnt(2);
        set_q(0, 16'hF000); set_q(1, 16'h0001);
        set_id(0, 16'h0077); set_id(1, 16'h0078);
        fire();
        wait_done(1'b0);
        check_result("hs_c", 6, 16'h0000, 16'hF000, 16'h0077, 1'b1);
    endtask

    initial begin
        clock = 1'b0;
        nrst  = 1'b0;
        en    = 1'b0;
        start = 1'b0;
        track = 1'b0;
        max_addr    = 16'h0000;
        last_q_addr = 16'h0000;
        clear_mem();

        test_reset();
        test_basic();
        test_reset_mid_scan();
        test_tie();
        test_empty();
        test_clamp();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
